i2s_ws_gen_tdm: RTL and testbench

Parametrised next-generation I2S word-select / frame-sync generator for the uDMA I2S master path. Supports three framing modes:
- standard I2S (WS one SCK early)
- left-justified
- DSP/TDM (one-SCK frame-sync pulse)

Slot width and slot count are configurable. Configuration is shadowed at frame boundaries, and disable is graceful (the current frame completes). The block also provides slot/frame strobes and the slot index to the serializer/deserializer.

---
 rtl/i2s_ws_gen_tdm.sv | 168 ++++++++++++++++
 tb/tb_i2s_ws_gen_tdm.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/i2s_ws_gen_tdm.sv
// i2s_ws_gen_tdm: word-select / frame-sync generator for the I2S master path.
// Framing: standard I2S, left-justified and DSP/TDM pulse. Slot width and
// slot count are shadowed at frame boundaries, and disabling the generator
// lets the current frame finish before it stops.
// Optional feature macro: I2S_WS_GEN_POL_EN adds cfg_ws_inv_i, which inverts
// ws_o and sets its idle level.
module i2s_ws_gen_tdm #(
  parameter int CNT_W  = 5,
  parameter int SLOT_W = 3
) (
  input  logic              sck_i,
  input  logic              rstn_i,
  input  logic              cfg_en_i,
  input  logic [1:0]        cfg_mode_i,
  input  logic [CNT_W-1:0]  cfg_slot_size_i,
  input  logic [SLOT_W-1:0] cfg_slot_num_i,
`ifdef I2S_WS_GEN_POL_EN
  input  logic              cfg_ws_inv_i,
`endif
  output logic              ws_o,
  output logic              slot_start_o,
  output logic              frame_start_o,
  output logic [SLOT_W-1:0] slot_idx_o,
  output logic              half_o,
  output logic              busy_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0]        MODE_LJ   = 2'b01;
  localparam logic [1:0]        MODE_DSP  = 2'b10;
  localparam logic [CNT_W-1:0]  BIT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  BIT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [SLOT_W-1:0] SLOT_ZERO = {SLOT_W{1'b0}};
  localparam logic [SLOT_W-1:0] SLOT_ONE  = {{(SLOT_W-1){1'b0}}, 1'b1};

  state_t              state_r;
  logic [CNT_W-1:0]    bit_cnt_r;
  logic [SLOT_W-1:0]   slot_cnt_r;
  logic                half_r;
  logic [1:0]          mode_r;
  logic [CNT_W-1:0]    size_r;
  logic [SLOT_W-1:0]   num_r;
  logic                inv_r;
  logic                ws_raw_r;
  logic                ws_r;

  logic                run_s;
  logic                is_dsp_s;
  logic                last_bit_s;
  logic                last_slot_s;
  logic                frame_end_s;
  logic                inv_nxt_s;
  logic                ws_raw_nxt_s;

`ifdef I2S_WS_GEN_POL_EN
  assign inv_nxt_s = cfg_ws_inv_i;
`else
  assign inv_nxt_s = 1'b0;
`endif

  // Decode counter positions against the shadowed frame geometry.
  always_comb begin
    run_s       = (state_r == RUN);
    is_dsp_s    = (mode_r == MODE_DSP);
    last_bit_s  = (bit_cnt_r == size_r);
    last_slot_s = last_bit_s && (slot_cnt_r == num_r);
    frame_end_s = run_s && last_slot_s && (is_dsp_s || half_r);
  end

  // Bit/slot/half counters and the IDLE/RUN state with config shadowing.
  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r    <= IDLE;
      bit_cnt_r  <= BIT_ZERO;
      slot_cnt_r <= SLOT_ZERO;
      half_r     <= 1'b0;
      mode_r     <= 2'b00;
      size_r     <= BIT_ZERO;
      num_r      <= SLOT_ZERO;
      inv_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          bit_cnt_r  <= BIT_ZERO;
          slot_cnt_r <= SLOT_ZERO;
          half_r     <= 1'b0;
          inv_r      <= inv_nxt_s;
          if (cfg_en_i) begin
            mode_r  <= cfg_mode_i;
            size_r  <= cfg_slot_size_i;
            num_r   <= cfg_slot_num_i;
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (frame_end_s) begin
            // Frame boundary: either pick up new config or stop cleanly.
            bit_cnt_r  <= BIT_ZERO;
            slot_cnt_r <= SLOT_ZERO;
            half_r     <= 1'b0;
            if (cfg_en_i) begin
              mode_r <= cfg_mode_i;
              size_r <= cfg_slot_size_i;
              num_r  <= cfg_slot_num_i;
              inv_r  <= inv_nxt_s;
            end else begin
              state_r <= IDLE;
            end
          end else if (!last_bit_s) begin
            bit_cnt_r <= bit_cnt_r + BIT_ONE;
          end else begin
            bit_cnt_r <= BIT_ZERO;
            if (!last_slot_s) begin
              slot_cnt_r <= slot_cnt_r + SLOT_ONE;
            end else begin
              // Half boundary inside a frame (I2S/LJ only reach here).
              slot_cnt_r <= SLOT_ZERO;
              half_r     <= is_dsp_s ? 1'b0 : ~half_r;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Next word-select level in the un-inverted domain, per framing mode.
  always_comb begin
    ws_raw_nxt_s = 1'b0;
    if (!run_s) begin
      ws_raw_nxt_s = 1'b0;
    end else begin
      case (mode_r)
        MODE_DSP: ws_raw_nxt_s = last_slot_s && cfg_en_i;
        MODE_LJ:  ws_raw_nxt_s = half_r;
        default:  ws_raw_nxt_s = last_slot_s ? ~ws_raw_r : ws_raw_r;
      endcase
    end
  end

  // Word select launched on the falling edge so it leads the next MSB.
  always_ff @(negedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ws_raw_r <= 1'b0;
      ws_r     <= 1'b0;
    end else begin
      ws_raw_r <= ws_raw_nxt_s;
      ws_r     <= ws_raw_nxt_s ^ inv_r;
    end
  end

  assign ws_o          = ws_r;
  assign busy_o        = run_s;
  assign slot_start_o  = run_s && (bit_cnt_r == BIT_ZERO);
  assign frame_start_o = run_s && (bit_cnt_r == BIT_ZERO) &&
                         (slot_cnt_r == SLOT_ZERO) && !half_r;
  assign slot_idx_o    = slot_cnt_r;
  assign half_o        = half_r;

endmodule

// File: tb/tb_i2s_ws_gen_tdm.sv
// Bench for i2s_ws_gen_tdm: a frame-position model predicts every output
// for each SCK cycle; predictions are queued when inputs are applied and
// compared after the falling edge that updates ws_o.
module tb_i2s_ws_gen_tdm;

  logic       sck;
  logic       rstn;
  logic       en;
  logic [1:0] mode;
  logic [4:0] ss;
  logic [2:0] sn;
  logic       ws;
  logic       slot_start;
  logic       frame_start;
  logic [2:0] slot_idx;
  logic       half;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: running flag, position inside frame, latched config.
  bit m_run;
  int m_pos;
  int m_mode;
  int m_ss;
  int m_sn;

  logic [7:0] exp_q[$];

  i2s_ws_gen_tdm #(.CNT_W(5), .SLOT_W(3)) dut (
    .sck_i           (sck),
    .rstn_i          (rstn),
    .cfg_en_i        (en),
    .cfg_mode_i      (mode),
    .cfg_slot_size_i (ss),
    .cfg_slot_num_i  (sn),
`ifdef I2S_WS_GEN_POL_EN
    .cfg_ws_inv_i    (1'b0),
`endif
    .ws_o            (ws),
    .slot_start_o    (slot_start),
    .frame_start_o   (frame_start),
    .slot_idx_o      (slot_idx),
    .half_o          (half),
    .busy_o          (busy)
  );

  initial sck = 1'b0;
  always #5 sck = ~sck;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic int frame_len();
    return (m_ss + 1) * (m_sn + 1) * ((m_mode == 2) ? 1 : 2);
  endfunction

  // Advance the model by one rising edge using the inputs now applied,
  // then return {busy, ws, slot_start, frame_start, half, slot_idx}.
  function automatic logic [7:0] model_step();
    int slotlen;
    int halflen;
    int b;
    int s;
    int h;
    logic w;
    if (!m_run) begin
      if (en) begin
        m_run = 1'b1; m_mode = mode; m_ss = ss; m_sn = sn; m_pos = 0;
      end
    end else if (m_pos == frame_len() - 1) begin
      if (en) begin
        m_mode = mode; m_ss = ss; m_sn = sn; m_pos = 0;
      end else begin
        m_run = 1'b0; m_pos = 0;
      end
    end else begin
      m_pos++;
    end
    if (!m_run) return 8'h00;
    slotlen = m_ss + 1;
    halflen = slotlen * (m_sn + 1);
    b = m_pos % slotlen;
    s = (m_pos / slotlen) % (m_sn + 1);
    h = (m_mode == 2) ? 0 : (m_pos / halflen);
    if (m_mode == 2)      w = (m_pos == frame_len() - 1) && en;
    else if (m_mode == 1) w = (h == 1);
    else                  w = (((m_pos + 1) / halflen) % 2) == 1;
    return {1'b1, w, (b == 0), (m_pos == 0), (h == 1), s[2:0]};
  endfunction

  task automatic run_cycles(input string tag, input int n);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model_step());
      @(negedge sck);
      #1;
      e = exp_q.pop_front();
      chk(tag, {24'h0, busy, ws, slot_start, frame_start, half, slot_idx}, {24'h0, e});
    end
  endtask

  task automatic set_cfg(input logic [1:0] md, input logic [4:0] size, input logic [2:0] num);
    mode = md; ss = size; sn = num;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ws"},    {31'h0, ws},          32'h0);
    chk({tag, "_busy"},  {31'h0, busy},        32'h0);
    chk({tag, "_sst"},   {31'h0, slot_start},  32'h0);
    chk({tag, "_fst"},   {31'h0, frame_start}, 32'h0);
    chk({tag, "_idx"},   {29'h0, slot_idx},    32'h0);
    chk({tag, "_half"},  {31'h0, half},        32'h0);
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0;
    set_cfg(2'b00, 5'd0, 3'd0);
    m_run = 1'b0; m_pos = 0; m_mode = 0; m_ss = 0; m_sn = 0;
    #1;
    check_all_zero("rst");
    @(negedge sck); @(negedge sck); #1;
    rstn = 1'b1;
    run_cycles("idle", 3);

    // I2S 16-bit slots, one slot per half.
    set_cfg(2'b00, 5'd15, 3'd0); en = 1'b1;
    run_cycles("i2s16", 70);
    en = 1'b0;
    run_cycles("i2s16_stop", 40);

    // Left-justified, 8-bit slots, two slots per half.
    set_cfg(2'b01, 5'd7, 3'd1); en = 1'b1;
    run_cycles("lj8x2", 70);
    en = 1'b0;
    run_cycles("lj8x2_stop", 40);

    // DSP 4x8: drop enable at bit 5 of slot 2 of the second frame.
    set_cfg(2'b10, 5'd7, 3'd3); en = 1'b1;
    run_cycles("dsp4x8", 54);
    en = 1'b0;
    run_cycles("dsp_stop", 20);
    en = 1'b1;
    run_cycles("dsp_restart", 40);
    en = 1'b0;
    run_cycles("dsp_stop2", 40);

    // 1-bit slots, single slot: every edge is a slot boundary.
    set_cfg(2'b00, 5'd0, 3'd0); en = 1'b1;
    run_cycles("i2s1", 9);
    set_cfg(2'b10, 5'd0, 3'd0);
    run_cycles("dsp1", 9);
    en = 1'b0;
    run_cycles("dsp1_stop", 4);

    // Mode 11 behaves as I2S; then maximum counter values.
    set_cfg(2'b11, 5'd3, 3'd1); en = 1'b1;
    run_cycles("mode3", 36);
    set_cfg(2'b01, 5'd31, 3'd7);
    run_cycles("ljmax", 530);
    en = 1'b0;
    run_cycles("ljmax_stop", 520);

    // Slot size change mid-frame only takes effect at the next frame.
    set_cfg(2'b00, 5'd15, 3'd0); en = 1'b1;
    run_cycles("resize_a", 20);
    ss = 5'd23;
    run_cycles("resize_b", 100);

    // Asynchronous reset in the middle of a frame.
    rstn = 1'b0;
    #1;
    check_all_zero("rst_mid");
    m_run = 1'b0; m_pos = 0;
    en = 1'b0;
    @(negedge sck); @(negedge sck); #1;
    check_all_zero("rst_hold");
    rstn = 1'b1;
    run_cycles("post_rst", 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
